// File: rtl/cpu_defs.sv
// Shared definitions for the fetch front end:
// opcodes, predictor modes, queue entry layout, immediates.
package cpu_defs;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int PRED_ALWAYS  = 0;
  localparam int PRED_NEVER   = 1;
  localparam int PRED_BIMODAL = 2;

  localparam logic [1:0] CTR_INIT = 2'b10;

  typedef enum logic {
    ST_RUN,
    ST_JWAIT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        is_c;
    logic        pred_taken;
    logic [31:0] pred_addr;
  } iq_entry_t;

  function automatic logic [31:0] imm_j(
    input logic [31:0] i
  );
    return {{12{i[31]}}, i[19:12], i[20],
            i[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(
    input logic [31:0] i
  );
    return {{20{i[31]}}, i[7], i[30:25],
            i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_bht.sv
// Bimodal branch history table: 2-bit saturating
// counters, async read, update visible next cycle.
import cpu_defs::*;

module bht #(
  parameter int IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_ctr_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam int N = 2 ** IDX_W;

  logic [1:0] ctr_q [N];
  logic [1:0] ctr_d;

  assign rd_ctr_o = ctr_q[rd_idx_i];

  // saturating step of the counter being updated
  always_comb begin
    ctr_d = ctr_q[upd_idx_i];
    if (upd_taken_i) begin
      if (ctr_d != 2'b11)
        ctr_d = ctr_d + 2'd1;
    end else begin
      if (ctr_d != 2'b00)
        ctr_d = ctr_d - 2'd1;
    end
  end

  // table reset to weakly taken, then commit updates
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++)
        ctr_q[i] <= CTR_INIT;
    end else if (en_i && upd_valid_i) begin
      ctr_q[upd_idx_i] <= ctr_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, predecode, branch prediction
// and an instruction queue toward the decoder.
import cpu_defs::*;

module fetch_unit #(
  parameter int          IQ_DEPTH  = 8,
  parameter int          PRED_MODE = 2,
  parameter int          BHT_IDX_W = 6,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        melt,
  input  logic [31:0] corr_jump_addr,
  output logic        if_enable,
  output logic [31:0] if_addr,
  input  logic        inst_ready,
  input  logic        is_c,
  input  logic [31:0] inst_val,
  output logic        q_valid,
  input  logic        q_ready,
  output logic [31:0] q_inst,
  output logic [31:0] q_addr,
  output logic        q_is_c,
  output logic        q_pred_taken,
  output logic [31:0] q_pred_addr,
  input  logic        upd_valid,
  input  logic [31:0] upd_addr,
  input  logic        upd_taken
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(IQ_DEPTH);

  fetch_state_e     st_q, st_d;
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  iq_entry_t        iq_q [IQ_DEPTH];
  iq_entry_t        ent;
  iq_entry_t        head_ent;
  logic             push;
  logic             pop;
  logic             pred_bit;
  logic             jwait_set;
  logic [31:0]      seq_pc;
  logic [6:0]       opc;

  assign opc = inst_val[6:0];

  assign if_enable = !clear
                   && (st_q == ST_RUN)
                   && (cnt_q < FULL);
  assign if_addr   = pc_q;

  assign push = rdy_in && inst_ready && if_enable;
  assign pop  = rdy_in && !clear
              && q_valid && q_ready;

  generate
    if (PRED_MODE == PRED_BIMODAL) begin : g_bht
      logic [1:0] ctr;
      logic       unused_bht;
      bht #(
        .IDX_W(BHT_IDX_W)
      ) u_bht (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .en_i       (rdy_in),
        .rd_idx_i   (pc_q[BHT_IDX_W:1]),
        .rd_ctr_o   (ctr),
        .upd_valid_i(upd_valid),
        .upd_idx_i  (upd_addr[BHT_IDX_W:1]),
        .upd_taken_i(upd_taken)
      );
      assign pred_bit   = ctr[1];
      assign unused_bht = ^{ctr[0],
                            upd_addr[31:BHT_IDX_W+1],
                            upd_addr[0]};
    end else begin : g_static
      logic unused_upd;
      assign pred_bit   = (PRED_MODE == PRED_ALWAYS);
      assign unused_upd = ^{upd_valid, upd_addr,
                            upd_taken};
    end
  endgenerate

  // predecode: build the entry and predicted next PC
  always_comb begin
    seq_pc         = pc_q + (is_c ? 32'd2 : 32'd4);
    jwait_set      = 1'b0;
    ent            = '0;
    ent.inst       = inst_val;
    ent.addr       = pc_q;
    ent.is_c       = is_c;
    ent.pred_taken = 1'b0;
    ent.pred_addr  = seq_pc;
    unique case (1'b1)
      (opc == OP_JAL): begin
        ent.pred_taken = 1'b1;
        ent.pred_addr  = pc_q + imm_j(inst_val);
      end
      (opc == OP_BRANCH): begin
        ent.pred_taken = pred_bit;
        if (pred_bit)
          ent.pred_addr = pc_q + imm_b(inst_val);
      end
      (opc == OP_JALR): begin
        jwait_set = 1'b1;
      end
      default: ;
    endcase
  end

  // next state: flush beats redirect beats push/pop
  always_comb begin
    st_d   = st_q;
    pc_d   = pc_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (clear) begin
      st_d   = ST_RUN;
      pc_d   = corr_jump_addr;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        pc_d   = ent.pred_addr;
        tail_d = tail_q + PTR_W'(1);
        if (jwait_set)
          st_d = ST_JWAIT;
      end
      if (melt) begin
        pc_d = corr_jump_addr;
        st_d = ST_RUN;
      end
      if (pop)
        head_d = head_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // control registers, frozen while rdy_in is low
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st_q   <= ST_RUN;
      pc_q   <= RESET_PC;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (rdy_in) begin
      st_q   <= st_d;
      pc_q   <= pc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // queue storage write at the tail
  always_ff @(posedge clk_in) begin
    if (!rst_in && push)
      iq_q[tail_q] <= ent;
  end

  assign q_valid = (cnt_q != '0);

  // head view, zeroed while the queue is empty
  always_comb begin
    head_ent = '0;
    if (q_valid)
      head_ent = iq_q[head_q];
  end

  assign q_inst       = head_ent.inst;
  assign q_addr       = head_ent.addr;
  assign q_is_c       = head_ent.is_c;
  assign q_pred_taken = head_ent.pred_taken;
  assign q_pred_addr  = head_ent.pred_addr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue, prediction,
// jalr stall, flush, PC wrap and reset.
module tb_fetch_unit;

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] BEQ  = 32'h02000063;
  localparam logic [31:0] JALR = 32'h00008067;
  localparam logic [31:0] JAL4 = 32'h0040006F;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        melt;
  logic [31:0] corr_jump_addr;
  logic        if_enable;
  logic [31:0] if_addr;
  logic        inst_ready;
  logic        is_c;
  logic [31:0] inst_val;
  logic        q_valid;
  logic        q_ready;
  logic [31:0] q_inst;
  logic [31:0] q_addr;
  logic        q_is_c;
  logic        q_pred_taken;
  logic [31:0] q_pred_addr;
  logic        upd_valid;
  logic [31:0] upd_addr;
  logic        upd_taken;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  fetch_unit dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clear         (clear),
    .melt          (melt),
    .corr_jump_addr(corr_jump_addr),
    .if_enable     (if_enable),
    .if_addr       (if_addr),
    .inst_ready    (inst_ready),
    .is_c          (is_c),
    .inst_val      (inst_val),
    .q_valid       (q_valid),
    .q_ready       (q_ready),
    .q_inst        (q_inst),
    .q_addr        (q_addr),
    .q_is_c        (q_is_c),
    .q_pred_taken  (q_pred_taken),
    .q_pred_addr   (q_pred_addr),
    .upd_valid     (upd_valid),
    .upd_addr      (upd_addr),
    .upd_taken     (upd_taken)
  );

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic redirect(input logic [31:0] a);
    clear = 1'b1;
    corr_jump_addr = a;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    clear = 1'b0;
    melt = 1'b0;
    corr_jump_addr = '0;
    inst_ready = 1'b1;
    is_c = 1'b0;
    inst_val = ADDI;
    q_ready = 1'b0;
    upd_valid = 1'b0;
    upd_addr = '0;
    upd_taken = 1'b0;
    cyc();
    cyc();

    // reset state; inst_ready during reset dropped
    rst_in = 1'b0;
    inst_ready = 1'b0;
    settle();
    chk("rst_q_valid", 32'(q_valid), 32'd0);
    chk("rst_q_inst", q_inst, 32'h0);
    chk("rst_q_addr", q_addr, 32'h0);
    chk("rst_q_pred_addr", q_pred_addr, 32'h0);
    chk("rst_q_is_c", 32'(q_is_c), 32'd0);
    chk("rst_q_pred_t", 32'(q_pred_taken), 32'd0);
    chk("rst_if_en", 32'(if_enable), 32'd1);
    chk("rst_if_addr", if_addr, 32'h0);

    // streaming addi with decoder always ready
    inst_ready = 1'b1;
    q_ready = 1'b1;
    settle();
    chk("s0_if_addr", if_addr, 32'h0);
    cyc();
    chk("s1_if_addr", if_addr, 32'h4);
    chk("s1_q_valid", 32'(q_valid), 32'd1);
    chk("s1_q_addr", q_addr, 32'h0);
    chk("s1_q_inst", q_inst, ADDI);
    cyc();
    chk("s2_if_addr", if_addr, 32'h8);
    chk("s2_q_addr", q_addr, 32'h4);
    cyc();
    inst_ready = 1'b0;
    chk("s3_q_addr", q_addr, 32'h8);
    cyc();
    chk("s4_empty", 32'(q_valid), 32'd0);
    chk("s4_if_addr", if_addr, 32'hC);

    // fill the queue with the decoder stalled
    q_ready = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("fill_if_en", 32'(if_enable), 32'd1);
      cyc();
    end
    settle();
    chk("full_if_en", 32'(if_enable), 32'd0);
    chk("full_if_addr", if_addr, 32'h2C);
    chk("full_q_addr", q_addr, 32'hC);
    q_ready = 1'b1;
    settle();
    chk("pop_cyc_if_en", 32'(if_enable), 32'd0);
    cyc();
    q_ready = 1'b0;
    settle();
    chk("after_pop_if_en", 32'(if_enable), 32'd1);
    chk("after_pop_q_addr", q_addr, 32'h10);
    cyc();
    settle();
    chk("refull_if_en", 32'(if_enable), 32'd0);
    chk("refull_if_addr", if_addr, 32'h30);

    // build five entries ending at pc 0x80
    inst_ready = 1'b0;
    redirect(32'h6C);
    inst_ready = 1'b1;
    repeat (5) cyc();
    inst_ready = 1'b0;
    settle();
    chk("five_if_addr", if_addr, 32'h80);
    chk("five_q_addr", q_addr, 32'h6C);

    // flush with concurrent push, pop and BHT update
    clear = 1'b1;
    corr_jump_addr = 32'h1000;
    q_ready = 1'b1;
    inst_ready = 1'b1;
    upd_valid = 1'b1;
    upd_addr = 32'h44;
    upd_taken = 1'b0;
    settle();
    chk("clr_if_en", 32'(if_enable), 32'd0);
    cyc();
    clear = 1'b0;
    q_ready = 1'b0;
    inst_ready = 1'b0;
    upd_valid = 1'b0;
    settle();
    chk("clr_q_valid", 32'(q_valid), 32'd0);
    chk("clr_q_inst", q_inst, 32'h0);
    chk("clr_if_addr", if_addr, 32'h1000);
    chk("clr_if_en2", 32'(if_enable), 32'd1);

    // bimodal: fresh counter predicts taken
    redirect(32'h40);
    inst_val = BEQ;
    inst_ready = 1'b1;
    settle();
    chk("bht0_if_addr", if_addr, 32'h40);
    cyc();
    inst_ready = 1'b0;
    chk("bht_taken_pc", if_addr, 32'h60);
    cyc();
    chk("bht_q_addr", q_addr, 32'h40);
    chk("bht_q_pt", 32'(q_pred_taken), 32'd1);
    chk("bht_q_pa", q_pred_addr, 32'h60);
    chk("bht_q_inst", q_inst, BEQ);

    // three not-taken updates saturate at 00
    upd_valid = 1'b1;
    upd_addr = 32'h40;
    upd_taken = 1'b0;
    repeat (3) cyc();
    upd_valid = 1'b0;
    redirect(32'h40);
    inst_ready = 1'b1;
    settle();
    chk("bht1_if_addr", if_addr, 32'h40);
    cyc();
    chk("bht_nt_pc", if_addr, 32'h44);
    cyc();
    chk("bht_clr_upd_pc", if_addr, 32'h48);
    cyc();
    chk("bht_fresh_pc", if_addr, 32'h68);

    // update and lookup at one index in one cycle
    upd_valid = 1'b1;
    upd_addr = 32'h68;
    upd_taken = 1'b0;
    cyc();
    upd_valid = 1'b0;
    inst_ready = 1'b0;
    chk("bht_old_val_pc", if_addr, 32'h88);
    chk("bht_head_pt", 32'(q_pred_taken), 32'd0);
    chk("bht_head_pa", q_pred_addr, 32'h44);

    // jalr stalls fetch until melt
    redirect(32'h10);
    inst_val = JALR;
    inst_ready = 1'b1;
    settle();
    chk("jalr_if_en0", 32'(if_enable), 32'd1);
    chk("jalr_if_addr0", if_addr, 32'h10);
    cyc();
    chk("jalr_wait_en", 32'(if_enable), 32'd0);
    chk("jalr_wait_pc", if_addr, 32'h14);
    cyc();
    chk("jalr_wait_en2", 32'(if_enable), 32'd0);
    chk("jalr_q_addr", q_addr, 32'h10);
    chk("jalr_q_pt", 32'(q_pred_taken), 32'd0);
    chk("jalr_q_pa", q_pred_addr, 32'h14);
    melt = 1'b1;
    corr_jump_addr = 32'h200;
    cyc();
    melt = 1'b0;
    inst_ready = 1'b0;
    settle();
    chk("melt_if_en", 32'(if_enable), 32'd1);
    chk("melt_if_addr", if_addr, 32'h200);

    // compressed jal wrapping past 2^32
    redirect(32'hFFFF_FFFE);
    inst_val = JAL4;
    is_c = 1'b1;
    inst_ready = 1'b1;
    settle();
    chk("wrap_if_addr0", if_addr, 32'hFFFF_FFFE);
    cyc();
    inst_ready = 1'b0;
    chk("wrap_if_addr", if_addr, 32'h2);
    cyc();
    is_c = 1'b0;
    chk("wrap_q_addr", q_addr, 32'hFFFF_FFFE);
    chk("wrap_q_is_c", 32'(q_is_c), 32'd1);
    chk("wrap_q_pt", 32'(q_pred_taken), 32'd1);
    chk("wrap_q_pa", q_pred_addr, 32'h2);

    // rdy_in low freezes everything
    rdy_in = 1'b0;
    inst_ready = 1'b1;
    q_ready = 1'b1;
    cyc();
    cyc();
    rdy_in = 1'b1;
    inst_ready = 1'b0;
    q_ready = 1'b0;
    settle();
    chk("rdy_if_addr", if_addr, 32'h2);
    chk("rdy_q_valid", 32'(q_valid), 32'd1);
    chk("rdy_q_addr", q_addr, 32'hFFFF_FFFE);

    // reset mid-operation discards everything
    rst_in = 1'b1;
    inst_ready = 1'b1;
    cyc();
    rst_in = 1'b0;
    inst_ready = 1'b0;
    settle();
    chk("rst2_q_valid", 32'(q_valid), 32'd0);
    chk("rst2_if_addr", if_addr, 32'h0);
    chk("rst2_if_en", 32'(if_enable), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
